instr_mem_responder: RTL and testbench

- Memory-side responder for the fetch stage's instruction requests.
- Loads a little-endian byte stream into an internal word array, then records the program size in bytes (rom_size).
- Serves fetch requests over a valid/ready request/response handshake, with a registered response.
- Replaces the wide flat ROM bus between top level and fetch.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_byte_packer.sv | 43 ++++
 rtl/instr_mem_responder.sv | 159 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory responder.
// Holds the load/serve state enum and the response bundle.
package imem_pkg;

  typedef enum logic {
    LOAD,
    SERVE
  } state_e;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] END_SENTINEL = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic        at_end;
    logic        misal;
  } rsp_t;

  function automatic logic [31:0] addr_to_idx(
    input logic [31:0] addr
  );
    return addr >> $clog2(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler for the program image load.
// Pulses o_word_valid on the 4th byte of a group or on i_last.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic        o_zero
);

  logic [1:0]  r_cnt;
  logic [23:0] r_acc;
  logic [31:0] w_word;

  // bytes above r_cnt are kept zero, so a partial group is zero-padded
  assign w_word = {8'h00, r_acc}
                | ({24'h0, i_byte} << {r_cnt, 3'b000});

  assign o_word       = w_word;
  assign o_word_valid = i_en && ((r_cnt == 2'd3) || i_last);
  assign o_zero       = (w_word == END_SENTINEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_acc <= 24'h0;
    end else if (i_en) begin
      if (o_word_valid) begin
        r_cnt <= 2'd0;
        r_acc <= 24'h0;
      end else begin
        r_cnt <= r_cnt + 2'd1;
        r_acc <= w_word[23:0];
      end
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory: byte-stream load, then valid/ready fetch service.
// Define IMEM_RSP_SKID_EN for a 2-entry response FIFO.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  input  logic            load_last,
  output logic            load_ready,
  output logic            loaded,
  output logic [XLEN-1:0] rom_size,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic            rsp_end,
  output logic            rsp_misaligned
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNTW-1:0]   r_wcnt;
  logic [31:0]       r_mem [DEPTH];
  logic              w_byte_en;
  logic              w_word_valid;
  logic              w_zero;
  logic              w_we;
  logic              w_full;
  logic [31:0]       w_word;
  logic              w_req_hs;
  logic [IDXW-1:0]   w_ridx;
  rsp_t              w_rsp_new;
  rsp_t              w_head;

  assign w_byte_en = load_valid && load_ready;

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .i_en         (w_byte_en),
    .i_byte       (load_byte),
    .i_last       (load_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_zero       (w_zero)
  );

  assign w_we   = w_word_valid && !w_zero;
  assign w_full = w_we && (r_wcnt == CNTW'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    loaded      = 1'b0;
    unique case (r_state)
      LOAD: begin
        load_ready = 1'b1;
        if (w_word_valid && (w_zero || load_last || w_full))
          w_state_nxt = SERVE;
      end
      SERVE: loaded = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_we)
        r_wcnt <= r_wcnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[r_wcnt[IDXW-1:0]] <= w_word;
  end

  assign rom_size = XLEN'({r_wcnt, 2'b00});
  assign w_ridx   = IDXW'(addr_to_idx(32'(req_addr)));
  assign w_req_hs = req_valid && req_ready;

  // out-of-image reads return zero and never touch unwritten words
  always_comb begin
    w_rsp_new        = '0;
    w_rsp_new.at_end = (req_addr >= rom_size);
    w_rsp_new.misal  = |req_addr[1:0];
    if (!w_rsp_new.at_end)
      w_rsp_new.instr = r_mem[w_ridx];
  end

`ifdef IMEM_RSP_SKID_EN
  rsp_t       r_fifo [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;
  logic       w_pop;

  assign req_ready = loaded && (r_cnt != 2'd2);
  assign rsp_valid = (r_cnt != 2'd0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_head    = r_fifo[r_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_req_hs) begin
        r_fifo[r_wp] <= w_rsp_new;
        r_wp         <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_req_hs} - {1'b0, w_pop};
    end
  end
`else
  logic r_rsp_v;
  rsp_t r_rsp;

  assign req_ready = loaded && (!r_rsp_v || rsp_ready);
  assign rsp_valid = r_rsp_v;
  assign w_head    = r_rsp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_v <= 1'b0;
      r_rsp   <= '0;
    end else if (w_req_hs) begin
      r_rsp_v <= 1'b1;
      r_rsp   <= w_rsp_new;
    end else if (rsp_ready) begin
      r_rsp_v <= 1'b0;
    end
  end
`endif

  assign rsp_instr      = XLEN'(w_head.instr);
  assign rsp_end        = w_head.at_end;
  assign rsp_misaligned = w_head.misal;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder with a byte-image model.
// Honours IMEM_RSP_SKID_EN for the stall-phase expectations.
module tb_instr_mem_responder;

  localparam int DEPTH = 256;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_valid;
  logic [7:0]      load_byte;
  logic            load_last;
  logic            load_ready;
  logic            loaded;
  logic [XLEN-1:0] rom_size;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic            rsp_end;
  logic            rsp_misaligned;

  instr_mem_responder #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .load_valid     (load_valid),
    .load_byte      (load_byte),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .loaded         (loaded),
    .rom_size       (rom_size),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_instr      (rsp_instr),
    .rsp_end        (rsp_end),
    .rsp_misaligned (rsp_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        e;
    logic        m;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];
  logic [31:0] mwords[DEPTH];
  int          mcount = 0;
  bit          rand_rdy = 0;
`ifdef IMEM_RSP_SKID_EN
  localparam logic STALL_RDY = 1'b1;
`else
  localparam logic STALL_RDY = 1'b0;
`endif

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: apply the image rules to a byte list
  task automatic model_load(input logic [7:0] b[$], input bit last);
    logic [31:0] w;
    int k;
    mcount = 0;
    w = 0;
    for (int i = 0; i < b.size(); i++) begin
      k = i % 4;
      w = w | (32'(b[i]) << (8 * k));
      if (k == 3 || (last && i == b.size() - 1)) begin
        if (w != 0) begin
          mwords[mcount] = w;
          mcount++;
        end
        if (w == 0 || (last && i == b.size() - 1) || mcount == DEPTH)
          break;
        w = 0;
      end
    end
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t r;
    r.e = (64'(a) >= 64'(mcount) * 4);
    r.m = (a[1:0] != 2'b00);
    r.instr = r.e ? 32'h0 : mwords[a / 4];
    return r;
  endfunction

  // monitor: compare responses, check hold-stability under backpressure
  logic [34:0] held;
  bit          held_v = 0;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (held_v)
        check("rsp_stable",
              64'({rsp_valid, rsp_instr, rsp_end, rsp_misaligned}),
              64'(held));
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("rsp_instr", 64'(rsp_instr), 64'(e.instr));
          check("rsp_end", 64'(rsp_end), 64'(e.e));
          check("rsp_misaligned", 64'(rsp_misaligned), 64'(e.m));
        end
      end
      held_v = rsp_valid && !rsp_ready;
      held = {rsp_valid, rsp_instr, rsp_end, rsp_misaligned};
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy)
      rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic load_bytes(input logic [7:0] b[$], input bit last);
    for (int i = 0; i < b.size(); i++) begin
      load_valid = 1'b1;
      load_byte  = b[i];
      load_last  = last && (i == b.size() - 1);
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, output int waited);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready)
      check("req_timeout", 64'(req_ready), 64'(1));
    else
      sbq.push_back(model(a));
    waited = n;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy  = 0;
    rsp_ready = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(sbq.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_loaded", 64'(loaded), 64'(0));
    check("rst_rom_size", 64'(rom_size), 64'(0));
    check("rst_rsp_instr", 64'(rsp_instr), 64'(0));
    sbq.delete();
    mcount = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_reqs(input int n, input int top);
    int w;
    rand_rdy = 1;
    for (int i = 0; i < n; i++) begin
      do_req(32'($urandom_range(0, top)), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
  endtask

  logic [7:0] bq[$];
  int         w;

  initial begin
    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    load_last  = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    rsp_ready  = 1'b1;
    #2;
    do_reset();
    check("load_ready_in_load", 64'(load_ready), 64'(1));
    check("req_ready_in_load", 64'(req_ready), 64'(0));

    bq = {8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00};
    model_load(bq, 0);
    load_bytes(bq, 0);
    check("rom_size_a", 64'(rom_size), 64'(mcount * 4));
    check("loaded_a", 64'(loaded), 64'(1));
    check("load_ready_a", 64'(load_ready), 64'(0));

    for (int i = 0; i < 3; i++) begin
      do_req(32'(4 * i), w);
      check("b2b_wait", 64'(w), 64'(0));
    end
    drain();

    rsp_ready = 1'b0;
    do_req(32'h4, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'(STALL_RDY));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    do_req(32'h0, w);
    check("resume_wait", 64'(w), 64'(0));
    do_req(32'h6, w);
    do_req(32'h400, w);
    drain();
    rand_reqs(30, mcount * 4 + 12);

    rsp_ready = 1'b0;
    do_req(32'h0, w);
    @(negedge clk);
    #2;
    do_reset();
    rsp_ready = 1'b1;

    bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    model_load(bq, 1);
    load_bytes(bq, 1);
    check("rom_size_b", 64'(rom_size), 64'(mcount * 4));
    check("loaded_b", 64'(loaded), 64'(1));
    do_req(32'h4, w);
    do_req(32'h0, w);
    do_req(32'h5, w);
    do_req(32'h8, w);
    drain();

    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_bytes(bq, 0);
    do_reset();
    check("load_ready_rst", 64'(load_ready), 64'(1));

    bq.delete();
    for (int i = 0; i < DEPTH * 4; i++)
      bq.push_back(8'($urandom_range(1, 255)));
    model_load(bq, 0);
    load_bytes(bq, 0);
    check("rom_size_full", 64'(rom_size), 64'(1024));
    check("load_ready_full", 64'(load_ready), 64'(0));
    check("loaded_full", 64'(loaded), 64'(1));
    do_req(32'h3fc, w);
    do_req(32'h400, w);
    do_req(32'hffff_fffd, w);
    drain();
    rand_reqs(40, DEPTH * 4 + 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
